mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences a shared-memory MIPS datapath (PC, IR, register file, ALU, unified memory). It replaces the single-cycle decoder and supports ADD, SUB, AND, OR, J, BEQ, BNE, ADDIU, LW and SW. It drives all datapath enables and muxes and waits on a memory ready handshake. It also flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, max consecutive wait cycles with mem_ready low before abort (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; stable outside FETCH
funct  in  6  IR[5:0]; stable outside FETCH
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes the current access this cycle
pc_we  out  1  PC write enable
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
iord  out  1  0 = memory address from PC, 1 = from ALUOut
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
ir_we  out  1  IR write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_we  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode/funct
mem_err  out  1  one-cycle pulse on memory timeout
instr_count  out  CNT_W  retired instructions; increments on instr_done; wraps to 0
state  out  4  current state encoding (debug)

Behaviour:
- Reset: rst=1 at a posedge sets state=FETCH(0), wait counter=0, instr_count=0. While rst=1, all outputs are forced to 0 (state output reads 0).
- Outputs are combinational from state, plus mem_ready, zero and opcode where noted. Unlisted outputs are 0 in each state.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- FETCH:
  - Always drives mem_rd=1, iord=0.
  - If mem_ready: ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, ADD (computes the branch target).
  - Next state by opcode: 0 with funct 32/34/36/37 goes to EXEC; 35/43 go to MEMADR; 4/5 go to BRANCH; 9 goes to ADDIEX; 2 goes to JUMP.
  - Anything else pulses illegal and returns to FETCH; no instr_done and no count.
- EXEC: alu_src_a=1, alu_src_b=00; alu_ctrl from funct (32 ADD, 34 SUB, 36 AND, 37 OR); next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_we=1, instr_done; next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD; next state MEMRD for opcode 35, MEMWR for opcode 43.
- MEMRD: iord=1, mem_rd=1; when mem_ready, next state MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_we=1, instr_done; next state FETCH.
- MEMWR: iord=1, mem_wr=1; when mem_ready, instr_done and next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, SUB, pc_src=01.
  - pc_we = (opcode==4 & zero) | (opcode==5 & ~zero).
  - instr_done; next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD; next state ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_we=1, instr_done; next state FETCH.
- JUMP: pc_src=10, pc_we=1, instr_done; next state FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR. Increments each cycle in those states while mem_ready=0.
  - When the counter equals MEM_TIMEOUT and mem_ready=0: mem_err pulses, the memory request is still held that cycle, and the next state is FETCH.
  - A timeout in FETCH therefore retries the fetch with the counter cleared. A timeout in MEMRD/MEMWR aborts the instruction: no reg_we, no instr_done.
- If mem_ready=1 arrives in the timeout cycle, it wins: normal completion, no mem_err.
- Cycle counts with zero wait states: R-type/ADDIU 4, LW 5, SW 4, BEQ/BNE 3, J 3.
- Reset mid-instruction: rst wins on that edge. No write enable asserts during or after the reset cycle until a new FETCH completes.
- instr_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- ADD (opcode 0, funct 32), mem_ready tied 1 → states 0,1,6,7; reg_we=1, reg_dst=1 in cycle 4; instr_done once; instr_count=1.
- LW (opcode 35) with mem_ready low for 3 cycles in MEMRD → stays in 3 for 4 cycles, then 4 with mem_to_reg=1; no mem_err; 8 cycles total.
- BEQ with zero=1 → pc_we=1, pc_src=01 in BRANCH. BNE with zero=1 → pc_we=0. Both pulse instr_done.
- SW with mem_ready held 0 → mem_err pulses on wait cycle 15; mem_wr is never dropped early; back to FETCH; instr_count unchanged.
- Opcode 6'h3F, or opcode 0 with funct 42 → illegal pulses in DECODE; next state FETCH; no reg_we; count unchanged.
- Assert rst in MEMWR, then J (opcode 2) → all outputs 0 during reset, state 0. J completes in 3 cycles with pc_src=10, pc_we=1; instr_count=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle control FSM for a shared-memory MIPS datapath (PC, IR, register
// file, ALU, unified memory). Supports ADD, SUB, AND, OR, J, BEQ, BNE, ADDIU,
// LW and SW, waits on a memory ready handshake, flags illegal opcodes and
// memory timeouts, and counts retired instructions.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0]
//   zero                ALU zero flag (current cycle)
//   mem_ready           memory completes the current access this cycle
//   pc_we, pc_src       PC write enable / source select
//   iord, mem_rd, mem_wr memory address select and requests
//   ir_we               instruction register write enable
//   reg_dst, mem_to_reg, reg_we   register file write controls
//   alu_src_a, alu_src_b, alu_ctrl ALU operand selects and operation
//   instr_done          pulse in the last cycle of each instruction
//   illegal             pulse when DECODE sees an unsupported instruction
//   mem_err             pulse on memory timeout
//   instr_count         retired instruction counter (wraps)
//   state               current state encoding (debug)
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  logic [3:0]       state_r;
  logic [3:0]       next_state_s;
  logic [7:0]       wait_cnt_r;
  logic [CNT_W-1:0] count_r;
  logic             timeout_s;

  logic       pc_we_s, iord_s, mem_rd_s, mem_wr_s, ir_we_s;
  logic       reg_dst_s, mem_to_reg_s, reg_we_s, alu_src_a_s;
  logic       done_s, illegal_s, mem_err_s;
  logic [1:0] pc_src_s, alu_src_b_s;
  logic [2:0] alu_ctrl_s;

  // Timeout only matters in the memory-waiting states; mem_ready wins over it.
  assign timeout_s = (wait_cnt_r == TIMEOUT_C) && !mem_ready;

  // Next-state and control output decode.
  always_comb begin
    next_state_s = state_r;
    pc_we_s      = 1'b0;
    pc_src_s     = 2'b00;
    iord_s       = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    ir_we_s      = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_we_s     = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_ctrl_s   = 3'b000;
    done_s       = 1'b0;
    illegal_s    = 1'b0;
    mem_err_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_rd_s = 1'b1;
        if (mem_ready) begin
          ir_we_s      = 1'b1;
          pc_we_s      = 1'b1;
          alu_src_b_s  = 2'b01;
          alu_ctrl_s   = ALU_ADD;
          next_state_s = S_DECODE;
        end else if (timeout_s) begin
          mem_err_s    = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b_s = 2'b11;
        alu_ctrl_s  = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if ((funct == FN_ADD) || (funct == FN_SUB) ||
                (funct == FN_AND) || (funct == FN_OR)) begin
              next_state_s = S_EXEC;
            end else begin
              illegal_s    = 1'b1;
              next_state_s = S_FETCH;
            end
          end
          OP_LW, OP_SW:   next_state_s = S_MEMADR;
          OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
          OP_ADDIU:       next_state_s = S_ADDIEX;
          OP_J:           next_state_s = S_JUMP;
          default: begin
            illegal_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        case (funct)
          FN_SUB:  alu_ctrl_s = ALU_SUB;
          FN_AND:  alu_ctrl_s = ALU_AND;
          FN_OR:   alu_ctrl_s = ALU_OR;
          default: alu_ctrl_s = ALU_ADD;
        endcase
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_s    = 1'b1;
        reg_we_s     = 1'b1;
        done_s       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_ctrl_s  = ALU_ADD;
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD: begin
        iord_s   = 1'b1;
        mem_rd_s = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else if (timeout_s) begin
          mem_err_s    = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_we_s     = 1'b1;
        done_s       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        iord_s   = 1'b1;
        mem_wr_s = 1'b1;
        if (mem_ready) begin
          done_s       = 1'b1;
          next_state_s = S_FETCH;
        end else if (timeout_s) begin
          mem_err_s    = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        alu_ctrl_s   = ALU_SUB;
        pc_src_s     = 2'b01;
        pc_we_s      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        done_s       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        alu_ctrl_s   = ALU_ADD;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we_s     = 1'b1;
        done_s       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_src_s     = 2'b10;
        pc_we_s      = 1'b1;
        done_s       = 1'b1;
        next_state_s = S_FETCH;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // State, wait counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= 8'd0;
      count_r    <= '0;
    end else begin
      state_r <= next_state_s;
      // Any state change (or a fetch retry after timeout) starts a fresh wait window.
      if ((next_state_s != state_r) || mem_err_s) begin
        wait_cnt_r <= 8'd0;
      end else if (!mem_ready) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (done_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // While reset is held every output reads zero, so no write enable can leak.
  assign pc_we       = pc_we_s & ~rst;
  assign pc_src      = rst ? 2'b00 : pc_src_s;
  assign iord        = iord_s & ~rst;
  assign mem_rd      = mem_rd_s & ~rst;
  assign mem_wr      = mem_wr_s & ~rst;
  assign ir_we       = ir_we_s & ~rst;
  assign reg_dst     = reg_dst_s & ~rst;
  assign mem_to_reg  = mem_to_reg_s & ~rst;
  assign reg_we      = reg_we_s & ~rst;
  assign alu_src_a   = alu_src_a_s & ~rst;
  assign alu_src_b   = rst ? 2'b00 : alu_src_b_s;
  assign alu_ctrl    = rst ? 3'b000 : alu_ctrl_s;
  assign instr_done  = done_s & ~rst;
  assign illegal     = illegal_s & ~rst;
  assign mem_err     = mem_err_s & ~rst;
  assign instr_count = rst ? '0 : count_r;
  assign state       = rst ? 4'd0 : state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. The reference model walks each
// instruction as a script of expected cycles (fetch/memory wait phases,
// fixed per-instruction step lists) and compares every cycle's state and
// full control vector. The counter is built 4 bits wide so wrap occurs.
module tb_mips_multicycle_ctrl;

  localparam int TO = 15;
  localparam int CW = 4;

  // Control vector bit masks:
  // {pc_we, pc_src[1:0], iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg,
  //  reg_we, alu_src_a, alu_src_b[1:0], alu_ctrl[2:0], instr_done, illegal, mem_err}
  localparam logic [18:0] P_WE     = 19'h40000;
  localparam logic [18:0] SRC_AOUT = 19'h10000;
  localparam logic [18:0] SRC_JMP  = 19'h20000;
  localparam logic [18:0] IORD     = 19'h08000;
  localparam logic [18:0] MRD      = 19'h04000;
  localparam logic [18:0] MWR      = 19'h02000;
  localparam logic [18:0] IRWE     = 19'h01000;
  localparam logic [18:0] RDST     = 19'h00800;
  localparam logic [18:0] M2R      = 19'h00400;
  localparam logic [18:0] RWE      = 19'h00200;
  localparam logic [18:0] SA_REG   = 19'h00100;
  localparam logic [18:0] SB_4     = 19'h00040;
  localparam logic [18:0] SB_IMM   = 19'h00080;
  localparam logic [18:0] SB_IMMSH = 19'h000C0;
  localparam logic [18:0] A_AND    = 19'h00000;
  localparam logic [18:0] A_OR     = 19'h00008;
  localparam logic [18:0] A_ADD    = 19'h00010;
  localparam logic [18:0] A_SUB    = 19'h00030;
  localparam logic [18:0] DONE     = 19'h00004;
  localparam logic [18:0] ILL      = 19'h00002;
  localparam logic [18:0] ERR      = 19'h00001;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we;
  logic          alu_src_a, instr_done, illegal, mem_err;
  logic [1:0]    pc_src, alu_src_b;
  logic [2:0]    alu_ctrl;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_we(reg_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  wire [18:0] obs_vec = {pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_dst,
                         mem_to_reg, reg_we, alu_src_a, alu_src_b, alu_ctrl,
                         instr_done, illegal, mem_err};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) return (fn == 6'd32) || (fn == 6'd34) || (fn == 6'd36) || (fn == 6'd37);
    return (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5) ||
           (op == 6'd9) || (op == 6'd2);
  endfunction

  function automatic logic [18:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'd34:   return A_SUB;
      6'd36:   return A_AND;
      6'd37:   return A_OR;
      default: return A_ADD;
    endcase
  endfunction

  // One clock cycle: drive at negedge, compare 1 time unit later, advance to posedge.
  task automatic step(input logic rdy, input logic z, input logic [3:0] exp_st,
                      input logic [18:0] exp_v, input string tag);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rdy;
    zero = z;
    #1;
    check_val({tag, "/state"}, {28'd0, state}, {28'd0, exp_st});
    check_val({tag, "/ctl"}, {13'd0, obs_vec}, {13'd0, exp_v});
    @(posedge clk);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'($urandom);
    zero = 1'($urandom);
    #1;
    check_val("rst/state", {28'd0, state}, 32'd0);
    check_val("rst/ctl", {13'd0, obs_vec}, 32'd0);
    check_val("rst/count", {28'd0, instr_count}, 32'd0);
    @(posedge clk);
    exp_cnt = 0;
  endtask

  // Memory wait phase. kind 0 = fetch, 1 = load, 2 = store.
  // waits = cycles with mem_ready low before it rises; more than TO means timeout.
  task automatic mem_phase(input int kind, input int waits, output bit ok);
    logic [3:0]  st;
    logic [18:0] wv, gv;
    ok = 1'b0;
    case (kind)
      0: begin st = 4'd0; wv = MRD;        gv = MRD | P_WE | IRWE | SB_4 | A_ADD; end
      1: begin st = 4'd3; wv = IORD | MRD; gv = IORD | MRD; end
      default: begin st = 4'd5; wv = IORD | MWR; gv = IORD | MWR | DONE; end
    endcase
    for (int i = 0; i <= TO; i++) begin
      if (i < waits) begin
        if (i == TO) begin
          step(1'b0, 1'($urandom), st, wv | ERR, "mem_timeout");
          return;
        end
        step(1'b0, 1'($urandom), st, wv, "mem_wait");
      end else begin
        step(1'b1, 1'($urandom), st, gv, "mem_go");
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic fetch_phase(input int fw);
    bit ok;
    mem_phase(0, fw, ok);
    if (!ok) mem_phase(0, 0, ok);
  endtask

  task automatic retire();
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    bit ok;
    bit taken;
    opcode = op;
    funct  = fn;
    fetch_phase(fw);
    if (!is_legal(op, fn)) begin
      step(1'($urandom), 1'($urandom), 4'd1, SB_IMMSH | A_ADD | ILL, "decode_illegal");
    end else begin
      step(1'($urandom), 1'($urandom), 4'd1, SB_IMMSH | A_ADD, "decode");
      case (op)
        6'd0: begin
          step(1'($urandom), 1'($urandom), 4'd6, SA_REG | alu_of(fn), "exec");
          step(1'($urandom), 1'($urandom), 4'd7, RDST | RWE | DONE, "aluwb");
          retire();
        end
        6'd35: begin
          step(1'($urandom), 1'($urandom), 4'd2, SA_REG | SB_IMM | A_ADD, "memadr_lw");
          mem_phase(1, mw, ok);
          if (ok) begin
            step(1'($urandom), 1'($urandom), 4'd4, M2R | RWE | DONE, "memwb");
            retire();
          end
        end
        6'd43: begin
          step(1'($urandom), 1'($urandom), 4'd2, SA_REG | SB_IMM | A_ADD, "memadr_sw");
          mem_phase(2, mw, ok);
          if (ok) retire();
        end
        6'd4, 6'd5: begin
          taken = (op == 6'd4) ? z : !z;
          step(1'($urandom), z, 4'd8,
               (taken ? P_WE : 19'd0) | SRC_AOUT | SA_REG | A_SUB | DONE, "branch");
          retire();
        end
        6'd9: begin
          step(1'($urandom), 1'($urandom), 4'd9, SA_REG | SB_IMM | A_ADD, "addiex");
          step(1'($urandom), 1'($urandom), 4'd10, RWE | DONE, "addiwb");
          retire();
        end
        default: begin
          step(1'($urandom), 1'($urandom), 4'd11, SRC_JMP | P_WE | DONE, "jump");
          retire();
        end
      endcase
    end
    #1;
    check_val("instr_count", {28'd0, instr_count}, exp_cnt);
  endtask

  initial begin
    int r, w, fw, mw;
    logic [5:0] op, fn;
    bit ok;
    rst = 1'b1;
    opcode = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    repeat (3) reset_cycle();

    // Directed cases.
    run_instr(6'd0, 6'd32, 1'b0, 0, 0);   // ADD, count 1
    run_instr(6'd35, 6'd0, 1'b0, 0, 3);   // LW with 3 wait cycles in MEMRD
    run_instr(6'd4, 6'd0, 1'b1, 0, 0);    // BEQ taken
    run_instr(6'd5, 6'd0, 1'b1, 0, 0);    // BNE not taken
    run_instr(6'd4, 6'd0, 1'b0, 0, 0);    // BEQ not taken
    run_instr(6'd5, 6'd0, 1'b0, 0, 0);    // BNE taken
    run_instr(6'd43, 6'd0, 1'b0, 0, 16);  // SW timeout, count unchanged
    run_instr(6'd43, 6'd0, 1'b0, 0, 15);  // SW ready in the timeout cycle wins
    run_instr(6'd35, 6'd0, 1'b0, 0, 16);  // LW timeout
    run_instr(6'd0, 6'd34, 1'b0, 16, 0);  // SUB with fetch timeout and retry
    run_instr(6'h3F, 6'd0, 1'b0, 0, 0);   // illegal opcode
    run_instr(6'd0, 6'd42, 1'b0, 0, 0);   // illegal funct
    run_instr(6'd0, 6'd36, 1'b0, 2, 0);   // AND
    run_instr(6'd0, 6'd37, 1'b0, 0, 0);   // OR
    run_instr(6'd9, 6'd0, 1'b0, 1, 0);    // ADDIU
    run_instr(6'd2, 6'd0, 1'b0, 0, 0);    // J

    // Reset while SW waits in MEMWR, then J from a clean start.
    opcode = 6'd43;
    funct = 6'd0;
    fetch_phase(0);
    step(1'b0, 1'b0, 4'd1, SB_IMMSH | A_ADD, "decode_sw");
    step(1'b0, 1'b0, 4'd2, SA_REG | SB_IMM | A_ADD, "memadr_sw");
    step(1'b0, 1'b0, 4'd5, IORD | MWR, "memwr_wait");
    reset_cycle();
    reset_cycle();
    run_instr(6'd2, 6'd0, 1'b0, 0, 0);    // count 1

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 11);
      fn = 6'd0;
      case (r)
        0: begin op = 6'd0; fn = 6'd32; end
        1: begin op = 6'd0; fn = 6'd34; end
        2: begin op = 6'd0; fn = 6'd36; end
        3: begin op = 6'd0; fn = 6'd37; end
        4: op = 6'd35;
        5: op = 6'd43;
        6: op = 6'd4;
        7: op = 6'd5;
        8: op = 6'd9;
        9: op = 6'd2;
        10: begin op = 6'($urandom); fn = 6'($urandom); end
        default: begin op = 6'd0; fn = 6'($urandom); end
      endcase
      w = $urandom_range(0, 9);
      fw = (w == 9) ? 15 + $urandom_range(0, 1) : w % 4;
      w = $urandom_range(0, 9);
      mw = (w == 9) ? 15 + $urandom_range(0, 1) : w % 4;
      run_instr(op, fn, 1'($urandom), fw, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
